bus_arbiter_8req: RTL and testbench
===================================

// Module: bus_arbiter_8req
// PURPOSE
//  Round-robin arbiter sharing the 16-bit 8-input operand mux among 8 requesters.
//  Drives the mux select (Sel -> mux Op) and a one-hot Grant back to requesters.
//  Bounds each tenure to MAX_BURST cycles so no requester can starve the bus.
//  Sits between the control unit's requesters and the datapath mux.
// PARAMETERS
//  MAX_BURST  4  cycles an owner may hold the bus before forced release (1..255)
// PORTS
//  CLK        in   1   system clock, rising edge
//  Reset      in   1   asynchronous, active-high reset
//  Req        in   8   Req[i]=1: requester i wants the bus; held high while using it
//  Lock       in   1   owner asks to exceed MAX_BURST (present only with ARB_LOCK_EN)
//  Grant      out  8   one-hot owner, all-zero when bus idle; registered
//  Sel        out  3   binary index of owner -> mux Op; holds last owner when idle
//  BusValid   out  1   1 while Grant != 0
//  GrantCount out  16  count of grant events (new tenures), saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async): Grant=0, Sel=0, BusValid=0, GrantCount=0, BurstCnt=0,
//    pointer Last=7 so Req[0] has top priority; state IDLE.
//  - States: IDLE (no owner), OWN (Grant one-hot). Only registers change on CLK edge.
//  - Pick: first set Req[i] scanning Last+1, Last+2, ... wrapping mod 8.
//  - IDLE: if Req!=0 -> OWN at next edge, Grant=onehot(pick), Sel=pick, Last=pick,
//    BurstCnt=1, GrantCount+=1. Latency Req->Grant: 1 cycle. Else stay IDLE.
//  - OWN, release when Req[Sel]==0 (voluntary) or BurstCnt==MAX_BURST (forced).
//    On release edge: if any Req (excl. owner if it dropped) -> new tenure same
//    edge, no idle gap, BusValid stays 1; since Last=old owner, old owner is
//    lowest priority and is regranted only if alone (counts as new tenure).
//    If no Req -> IDLE, Grant=0, BusValid=0, Sel unchanged.
//  - OWN, no release: BurstCnt+=1; Grant/Sel stable. Req changes of non-owners
//    never affect current tenure.
//  - Voluntary and forced release on the same edge: treated as one release.
//  - GrantCount saturates; never wraps.
//  - MAX_BURST=1: every cycle re-arbitrates (pure round-robin per cycle).
//  - Reset mid-tenure: all outputs return to reset values immediately.
//  - Invariant: Grant is 0 or one-hot; Grant!=0 implies Grant[Sel]==1.
// CONFIGURATION
//  ARB_LOCK_EN defined: Lock port exists; in OWN with Req[Sel]&Lock, forced release
//    suppressed, BurstCnt saturates at MAX_BURST; dropping Lock with
//    BurstCnt==MAX_BURST releases on next edge. Voluntary release unaffected.
//  ARB_LOCK_EN undefined: no Lock port; forced release always applies.
// STRUCTURE
//  Package arb_pkg: NREQ=8, SEL_W=3, GCNT_W=16, state encoding IDLE/OWN.
//  Sub-module rr_pick8: combinational (Req[7:0], Last[2:0]) -> (Any, Pick[2:0]).
//  Top holds FSM, BurstCnt (8b), Last, Grant/Sel regs, GrantCount.
// TESTING
//  1 Reset, Req=8'h00 -> Grant=0, Sel=0, BusValid=0, GrantCount=0 indefinitely.
//  2 Req=8'h81 from reset -> Grant=8'h01 one cycle later, Sel=0; drop Req[0]
//    -> next edge Grant=8'h80, Sel=7, GrantCount=2, BusValid never drops.
//  3 MAX_BURST=4, Req=8'h04 held -> Grant=8'h04 for 4 cycles, then regranted
//    (alone), GrantCount increments every 4 cycles.
//  4 Req=8'hFF held, MAX_BURST=1 -> Sel sequence 0,1,2,...,7,0 one per cycle.
//  5 Owner 3 locked (ARB_LOCK_EN), Req=8'h28 -> Grant=8'h08 beyond 4 cycles;
//    Lock=0 -> next edge Grant=8'h20, Sel=5.
//  6 Assert Reset during tenure with Req=8'hFF -> outputs zero same cycle;
//    after release Grant=8'h01 first (Last=7).

Source files
------------

// File: rtl/bus_arbiter_8req_pkg.sv
// arb_pkg: shared sizes, FSM state encoding and a one-hot helper for the
// 8-requester round-robin bus arbiter (bus_arbiter_8req).
// Optional feature macro used by the arbiter files: ARB_LOCK_EN.
package arb_pkg;

    localparam int NREQ   = 8;   // number of requesters
    localparam int SEL_W  = 3;   // width of the binary owner index
    localparam int GCNT_W = 16;  // grant event counter width
    localparam int BCNT_W = 8;   // tenure length counter width (MAX_BURST <= 255)

    typedef enum logic {
        IDLE = 1'b0,   // no owner, Grant all-zero
        OWN  = 1'b1    // Grant one-hot
    } arb_state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_8req_if.sv
// bus_arbiter_8req_if: request/grant bundle between the requesters and the
// arbiter.
//   Req        requester -> arbiter  8b  per-requester bus request
//   Lock       requester -> arbiter  1b  owner asks to exceed MAX_BURST
//                                        (exists only with ARB_LOCK_EN)
//   Grant      arbiter -> requester  8b  one-hot owner, zero when idle
//   Sel        arbiter -> mux        3b  binary owner index
//   BusValid   arbiter -> requester  1b  Grant != 0
//   GrantCount arbiter -> requester  16b saturating count of tenures
// Modports: master = arbiter side, slave = requester/mux side.
interface bus_arbiter_8req_if;
    import arb_pkg::*;

    logic [NREQ-1:0]   Req;
`ifdef ARB_LOCK_EN
    logic              Lock;
`endif
    logic [NREQ-1:0]   Grant;
    logic [SEL_W-1:0]  Sel;
    logic              BusValid;
    logic [GCNT_W-1:0] GrantCount;

    modport master (
        input  Req,
`ifdef ARB_LOCK_EN
        input  Lock,
`endif
        output Grant, Sel, BusValid, GrantCount
    );

    modport slave (
        output Req,
`ifdef ARB_LOCK_EN
        output Lock,
`endif
        input  Grant, Sel, BusValid, GrantCount
    );

endinterface

// File: rtl/bus_arbiter_8req_rr_pick8.sv
// rr_pick8: combinational round-robin picker. Finds the first set bit of req
// scanning last+1, last+2, ... wrapping mod 8, so requester 'last' is checked
// last of all.
//   req  in  8b  request vector
//   last in  3b  index of the previous owner (lowest priority)
//   any  out 1b  req != 0
//   pick out 3b  selected index (0 when any == 0)
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] pick
);

    logic [SEL_W-1:0] idx;

    // Walk the scan order from farthest (offset 8 == last itself) to nearest
    // (offset 1); later assignments win, so the nearest hit survives.
    always_comb begin
        any  = |req;
        pick = '0;
        idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) pick = idx;
        end
    end

endmodule

// File: rtl/bus_arbiter_8req.sv
// bus_arbiter_8req: round-robin arbiter for the 8-input operand mux.
// Each tenure lasts until the owner drops its Req or has held the bus for
// MAX_BURST cycles; the next owner is granted on the same edge, so there is
// no idle gap while anyone is requesting.
//   CLK    in  system clock, rising edge
//   Reset  in  asynchronous active-high reset
//   bus    bus_arbiter_8req_if.master (Req/Lock in, Grant/Sel/BusValid/
//          GrantCount out, all outputs registered)
// Optional feature macro: ARB_LOCK_EN -- adds Lock; a locked owner is not
// forced off after MAX_BURST cycles.
module bus_arbiter_8req
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    bus_arbiter_8req_if.master  bus
);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [BCNT_W-1:0] burst_q, burst_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic              bv_q, bv_d;

    logic              any;
    logic [SEL_W-1:0]  pick;
    logic              owner_req;
    logic              burst_max;
    logic              lock_hold;
    logic              release_now;
    logic              new_tenure;

    // A dropped owner already has its Req bit clear, so the raw Req vector
    // is the right candidate set; last_q == sel_q while owning makes the
    // old owner lowest priority.
    rr_pick8 u_pick (
        .req  (bus.Req),
        .last (last_q),
        .any  (any),
        .pick (pick)
    );

    assign owner_req = bus.Req[sel_q];
    assign burst_max = (burst_q == BCNT_W'(MAX_BURST));

`ifdef ARB_LOCK_EN
    assign lock_hold = owner_req & bus.Lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Voluntary and forced release collapse into a single release event.
    assign release_now = !owner_req || (burst_max && !lock_hold);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        last_d     = last_q;
        burst_d    = burst_q;
        gcnt_d     = gcnt_q;
        bv_d       = bv_q;
        new_tenure = 1'b0;

        case (state_q)
            IDLE: begin
                if (any) new_tenure = 1'b1;
            end
            OWN: begin
                if (release_now) begin
                    if (any) begin
                        new_tenure = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        bv_d    = 1'b0;
                        burst_d = '0;
                    end
                end else if (!burst_max) begin
                    // Saturates at MAX_BURST while a lock holds the bus.
                    burst_d = burst_q + BCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_tenure) begin
            state_d = OWN;
            grant_d = onehot(pick);
            sel_d   = pick;
            last_d  = pick;
            burst_d = BCNT_W'(1);
            bv_d    = 1'b1;
            gcnt_d  = (gcnt_q == '1) ? gcnt_q : gcnt_q + GCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NREQ - 1);   // requester 0 first after reset
            burst_q <= '0;
            gcnt_q  <= '0;
            bv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            gcnt_q  <= gcnt_d;
            bv_q    <= bv_d;
        end
    end

    assign bus.Grant      = grant_q;
    assign bus.Sel        = sel_q;
    assign bus.BusValid   = bv_q;
    assign bus.GrantCount = gcnt_q;

endmodule

// File: tb/tb_bus_arbiter_8req.sv
// tb_bus_arbiter_8req: directed self-checking bench for bus_arbiter_8req.
// Two instances: u_dut4 (MAX_BURST=4) and u_dut1 (MAX_BURST=1).
// Inputs change and outputs are sampled on the falling edge.
module tb_bus_arbiter_8req;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter_8req_if ifc4 ();
    bus_arbiter_8req_if ifc1 ();

    bus_arbiter_8req #(.MAX_BURST(4)) u_dut4 (.CLK(clk), .Reset(rst), .bus(ifc4));
    bus_arbiter_8req #(.MAX_BURST(1)) u_dut1 (.CLK(clk), .Reset(rst), .bus(ifc1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ifc4.Req = 8'h00;
        ifc1.Req = 8'h00;
`ifdef ARB_LOCK_EN
        ifc4.Lock = 1'b0;
        ifc1.Lock = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] expg;
        int         k;

        // 1: reset values, and they persist with no requests
        do_reset();
        check("rst_grant", ifc4.Grant, 8'h00);
        check("rst_sel", ifc4.Sel, 3'd0);
        check("rst_bv", ifc4.BusValid, 1'b0);
        check("rst_gc", ifc4.GrantCount, 16'd0);
        tick(); tick(); tick();
        check("idle_grant", ifc4.Grant, 8'h00);
        check("idle_bv", ifc4.BusValid, 1'b0);
        check("idle_gc", ifc4.GrantCount, 16'd0);
        check("idle1_grant", ifc1.Grant, 8'h00);

        // 2: 0 first, voluntary drop hands over to 7 with no gap
        do_reset();
        ifc4.Req = 8'h81;
        tick();
        check("t2_grant0", ifc4.Grant, 8'h01);
        check("t2_sel0", ifc4.Sel, 3'd0);
        check("t2_bv0", ifc4.BusValid, 1'b1);
        check("t2_gc0", ifc4.GrantCount, 16'd1);
        ifc4.Req = 8'h80;
        tick();
        check("t2_grant7", ifc4.Grant, 8'h80);
        check("t2_sel7", ifc4.Sel, 3'd7);
        check("t2_bv7", ifc4.BusValid, 1'b1);
        check("t2_gc7", ifc4.GrantCount, 16'd2);
        ifc4.Req = 8'h00;
        tick();
        check("t2_idle_grant", ifc4.Grant, 8'h00);
        check("t2_idle_sel", ifc4.Sel, 3'd7);
        check("t2_idle_bv", ifc4.BusValid, 1'b0);
        check("t2_idle_gc", ifc4.GrantCount, 16'd2);

        // 3: lone requester 2 regranted every 4 cycles
        do_reset();
        ifc4.Req = 8'h04;
        for (int n = 1; n <= 9; n++) begin
            tick();
            check("t3_grant", ifc4.Grant, 8'h04);
            check("t3_gc", ifc4.GrantCount, 32'(1 + (n - 1) / 4));
        end

        // 3b: forced release with contention alternates 2 and 4
        do_reset();
        ifc4.Req = 8'h14;
        for (int n = 1; n <= 12; n++) begin
            tick();
            expg = (((n - 1) / 4) % 2 == 0) ? 8'h04 : 8'h10;
            check("t3b_grant", ifc4.Grant, expg);
        end

        // 4: MAX_BURST=1 with all requesting rotates every cycle
        do_reset();
        ifc1.Req = 8'hFF;
        for (int n = 1; n <= 9; n++) begin
            tick();
            k    = (n - 1) % 8;
            expg = 8'h01 << k;
            check("t4_sel", ifc1.Sel, 32'(k));
            check("t4_grant", ifc1.Grant, expg);
            check("t4_gc", ifc1.GrantCount, 32'(n));
        end

        // 5: owner 3 with requester 5 waiting
        do_reset();
        ifc4.Req = 8'h28;
`ifdef ARB_LOCK_EN
        ifc4.Lock = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            check("t5_lock_grant", ifc4.Grant, 8'h08);
        end
        ifc4.Lock = 1'b0;
        tick();
        check("t5_unlock_grant", ifc4.Grant, 8'h20);
        check("t5_unlock_sel", ifc4.Sel, 3'd5);
        check("t5_unlock_gc", ifc4.GrantCount, 16'd2);
`else
        for (int n = 1; n <= 4; n++) begin
            tick();
            check("t5_grant3", ifc4.Grant, 8'h08);
        end
        tick();
        check("t5_grant5", ifc4.Grant, 8'h20);
        check("t5_sel5", ifc4.Sel, 3'd5);
        check("t5_gc", ifc4.GrantCount, 16'd2);
`endif

        // 6: async reset mid-tenure, then restart from requester 0
        do_reset();
        ifc4.Req = 8'hFF;
        tick();
        tick();
        check("t6_pre_grant", ifc4.Grant, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_grant", ifc4.Grant, 8'h00);
        check("t6_rst_sel", ifc4.Sel, 3'd0);
        check("t6_rst_bv", ifc4.BusValid, 1'b0);
        check("t6_rst_gc", ifc4.GrantCount, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_grant", ifc4.Grant, 8'h01);
        check("t6_post_sel", ifc4.Sel, 3'd0);
        check("t6_post_gc", ifc4.GrantCount, 16'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
